// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign-corrected results registered on the final step with a one-cycle done pulse.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_p;      // partial remainder
    logic [WIDTH-1:0] work;       // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] orig_dvd;
    logic             sign_q;
    logic             sign_r;
    logic             zero_dvs;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] work_next;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic             last;

    always_comb begin
        a_neg = is_signed & dividend[WIDTH-1];
        b_neg = is_signed & divisor[WIDTH-1];
        a_mag = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag = b_neg ? (~divisor + 1'b1) : divisor;

        // The comparison needs the shifted-out top bit; the difference itself
        // always fits in WIDTH bits whenever it is kept (it is below the divisor).
        shifted   = {rem_p, work[WIDTH-1]};
        ge        = (shifted >= {1'b0, div_mag});
        diff      = shifted[WIDTH-1:0] - div_mag;
        rem_next  = ge ? diff : shifted[WIDTH-1:0];
        work_next = {work[WIDTH-2:0], ge};

        q_fin = zero_dvs ? '1 : (sign_q ? (~work_next + 1'b1) : work_next);
        r_fin = zero_dvs ? orig_dvd : (sign_r ? (~rem_next + 1'b1) : rem_next);
        last  = (count == CW'(WIDTH - 1));
    end

    // NOTE: the last restoring step and the result load share one edge, so
    // outputs are loaded from the combinational next-step values, not from rem_p/work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            rem_p     <= '0;
            work      <= '0;
            div_mag   <= '0;
            orig_dvd  <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zero_dvs  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done <= 1'b0;
                    if (start) begin
                        work     <= a_mag;
                        div_mag  <= b_mag;
                        orig_dvd <= dividend;
                        sign_q   <= a_neg ^ b_neg;
                        sign_r   <= a_neg;
                        zero_dvs <= (divisor == '0);
                        rem_p    <= '0;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem_p <= rem_next;
                    work  <= work_next;
                    count <= count + CW'(1);
                    if (last) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                        div_zero  <= zero_dvs;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
